// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seq_pkg
//  Description : Shared types and helpers for the layer sequencer: the FSM
//                state enum, the default index width, the {ch,row,col}
//                index triple and a packed-parameter field extractor.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

   // Default width of one index field (channel, row or column).
   localparam int SEQ_IDX_W    = 16;

   // Upper bounds accepted by pkd_field; the top checks its parameters
   // against them at elaboration.
   localparam int MAX_PACKED_W = 1024;
   localparam int MAX_FIELD_W  = 32;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      XFER   = 3'd3,
      DRAIN  = 3'd4,
      FIN    = 3'd5
   } state_e;

   // Index triple at the default width. The packed order matches the
   // {ch,row,col} layout of rd_index / wr_index.
   typedef struct packed {
      logic [SEQ_IDX_W-1:0] ch;
      logic [SEQ_IDX_W-1:0] row;
      logic [SEQ_IDX_W-1:0] col;
   } idx3_t;

   // Extract field 'idx' of width 'w' from a packed per-layer parameter,
   // field 0 at the LSB. Used on constants only.
   function automatic logic [MAX_FIELD_W-1:0] pkd_field(
      input logic [MAX_PACKED_W-1:0] vec,
      input int unsigned             idx,
      input int unsigned             w
   );
      logic [MAX_PACKED_W-1:0] sh;
      sh        = vec >> (idx * w);
      pkd_field = sh[MAX_FIELD_W-1:0] &
                  ((MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1));
   endfunction

endpackage : seq_pkg
`default_nettype wire

// File: rtl/seq_index_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_index_counter
//  Description : 3-D wrap counter walking (ch,row,col), col fastest. Column
//                and row wrap at dim_max_i, channel wraps at ch_max_i.
//  Ports       : clk, reset_n   - clock, async active-low reset
//                clear_i        - force index to (0,0,0) (priority over step)
//                step_i         - advance one position
//                ch_max_i       - last channel value
//                dim_max_i      - last row/col value
//                idx_o          - {ch,row,col}
//                last_o         - index is at the final position
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_index_counter
   import seq_pkg::*;
#(
   parameter int IDX_W = SEQ_IDX_W
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clear_i,
   input  logic               step_i,
   input  logic [IDX_W-1:0]   ch_max_i,
   input  logic [IDX_W-1:0]   dim_max_i,
   output logic [3*IDX_W-1:0] idx_o,
   output logic               last_o
);

   logic [IDX_W-1:0] ch_q, row_q, col_q;
   logic [IDX_W-1:0] ch_d, row_d, col_d;
   logic             w_col_wrap, w_row_wrap, w_ch_wrap;

   always_comb begin
      w_col_wrap = (col_q == dim_max_i);
      w_row_wrap = (row_q == dim_max_i);
      w_ch_wrap  = (ch_q  == ch_max_i);
      ch_d       = ch_q;
      row_d      = row_q;
      col_d      = col_q;
      if (clear_i) begin
         ch_d  = '0;
         row_d = '0;
         col_d = '0;
      end else if (step_i) begin
         if (w_col_wrap) begin
            col_d = '0;
            if (w_row_wrap) begin
               row_d = '0;
               ch_d  = w_ch_wrap ? '0 : ch_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch_q  <= '0;
         row_q <= '0;
         col_q <= '0;
      end else begin
         ch_q  <= ch_d;
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign idx_o  = {ch_q, row_q, col_q};
   assign last_o = w_col_wrap & w_row_wrap & w_ch_wrap;

endmodule : seq_index_counter
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Runs NUM_LAYERS compute layers in order. Each layer gets a
//                start pulse; after its done, its output memory is streamed
//                into the next layer's input memory by a (ch,row,col) walk.
//  Ports       : clk, reset_n    - clock, async active-low reset
//                start, abort    - begin pass (IDLE only) / cancel pass
//                busy, done      - pass active / 1-cycle completion pulse
//                layer_start     - one-hot compute pulse to layer k
//                layer_done      - completion from each layer
//                rd_index        - {ch,row,col} read of layer k output memory
//                wr_index, wr_en - write into layer k+1 input memory
//                cur_layer       - active layer index k
//                perf_cycles     - busy-cycle counter (SEQ_PERF_CNT_EN only)
//  Config      : define SEQ_PERF_CNT_EN to add the perf_cycles counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer
   import seq_pkg::*;
#(
   parameter int NUM_LAYERS = 4,
   parameter int IDX_W      = SEQ_IDX_W,
   parameter logic [NUM_LAYERS*IDX_W-1:0] LAYER_OUT_CH  =
      {16'd32, 16'd32, 16'd16, 16'd16},
   parameter logic [NUM_LAYERS*IDX_W-1:0] LAYER_OUT_DIM =
      {16'd5, 16'd11, 16'd13, 16'd26}
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   output logic                  busy,
   output logic                  done,
   output logic [NUM_LAYERS-1:0] layer_start,
   input  logic [NUM_LAYERS-1:0] layer_done,
   output logic [3*IDX_W-1:0]    rd_index,
   output logic [3*IDX_W-1:0]    wr_index,
   output logic [NUM_LAYERS-1:0] wr_en,
   output logic [IDX_W-1:0]      cur_layer
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]           perf_cycles
`else
   // perf_cycles port not present in this build
`endif
);

   localparam int K_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   // ------------------------------------------------------------------
   // Per-layer wrap limits, unpacked from the packed parameters
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] w_ch_max  [NUM_LAYERS];
   logic [IDX_W-1:0] w_dim_max [NUM_LAYERS];

   if (NUM_LAYERS < 1 || IDX_W < 1 || IDX_W > MAX_FIELD_W ||
       NUM_LAYERS * IDX_W > MAX_PACKED_W) begin : g_bad_cfg
      $error("layer_sequencer: unsupported NUM_LAYERS/IDX_W combination");
   end

   for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_dims
      localparam logic [MAX_FIELD_W-1:0] C_CH  =
         pkd_field(MAX_PACKED_W'(LAYER_OUT_CH), g, IDX_W);
      localparam logic [MAX_FIELD_W-1:0] C_DIM =
         pkd_field(MAX_PACKED_W'(LAYER_OUT_DIM), g, IDX_W);

      if (C_CH == 0 || C_DIM == 0) begin : g_bad_dim
         $error("layer_sequencer: layer %0d has zero channels or dimension", g);
      end

      assign w_ch_max[g]  = IDX_W'(C_CH - 1);
      assign w_dim_max[g] = IDX_W'(C_DIM - 1);
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_e             state_q, state_d;
   logic [K_W-1:0]     k_q, k_d;
   logic               wr_vld_q, wr_vld_d;
   logic [3*IDX_W-1:0] wr_idx_q, wr_idx_d;

   logic [3*IDX_W-1:0] w_rd_idx;
   logic               w_cnt_last;
   logic               w_cnt_clear;
   logic               w_cnt_step;
   logic               w_last_layer;

   assign w_last_layer = (k_q == K_W'(NUM_LAYERS - 1));

   // The counter sits at (0,0,0) whenever the next state is not XFER, so
   // it is ready on the first transfer cycle and rd_index reads zero
   // outside transfers (including straight after an abort).
   seq_index_counter #(
      .IDX_W     (IDX_W)
   ) u_idx_cnt (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear_i   (w_cnt_clear),
      .step_i    (w_cnt_step),
      .ch_max_i  (w_ch_max[k_q]),
      .dim_max_i (w_dim_max[k_q]),
      .idx_o     (w_rd_idx),
      .last_o    (w_cnt_last)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         wr_vld_q <= 1'b0;
         wr_idx_q <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         wr_vld_q <= wr_vld_d;
         wr_idx_q <= wr_idx_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
         k_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d = LAUNCH;
                  k_d     = '0;
               end
            end
            LAUNCH: state_d = WAIT;
            WAIT: begin
               if (layer_done[k_q]) begin
                  state_d = w_last_layer ? FIN : XFER;
               end
            end
            XFER: begin
               if (w_cnt_last) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               state_d = LAUNCH;
               k_d     = k_q + 1'b1;
            end
            FIN: begin
               state_d = IDLE;
               k_d     = '0;
            end
            default: begin
               state_d = IDLE;
               k_d     = '0;
            end
         endcase
      end

      w_cnt_clear = (state_d != XFER);
      w_cnt_step  = (state_q == XFER);

      // Output memories read with one cycle of latency, so the write side
      // is the read index delayed by one register stage.
      wr_vld_d = (state_q == XFER) && !abort;
      wr_idx_d = wr_vld_d ? w_rd_idx : '0;
   end

   // Output logic
   always_comb begin
      busy        = (state_q != IDLE);
      done        = (state_q == FIN);
      layer_start = (state_q == LAUNCH) ? (NUM_LAYERS'(1) << k_q) : '0;
      // Destination is layer k+1; shifting 2 by k keeps bit 0 clear.
      wr_en       = wr_vld_q ? (NUM_LAYERS'(2) << k_q) : '0;
      rd_index    = w_rd_idx;
      wr_index    = wr_idx_q;
      cur_layer   = IDX_W'(k_q);
   end

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_q <= '0;
      end else if (state_q == IDLE && start) begin
         perf_q <= '0;
      end else if (state_q != IDLE && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles = perf_q;
`else
   // No performance counter in this build.
`endif

endmodule : layer_sequencer
`default_nettype wire
